display_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for the 4-digit seven-segment display. It shares a single segment decoder across four digit "requesters", rotating through them with a fixed slot time and a blanking gap to suppress ghosting. New display contents are double-buffered and only take effect at a frame boundary, so a frame never shows half old and half new data. It sits between the board-level segment/anode pins and the encoder logic that produces digit values.

---
 rtl/display_scan_ctrl_pkg.sv | 15 +
 rtl/display_scan_ctrl_hex7seg.sv | 28 ++
 rtl/display_scan_ctrl.sv | 59 +++++
 tb/tb_display_scan_ctrl.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/display_scan_ctrl_pkg.sv
// display_scan_ctrl_pkg: shared segment constants, state encodings and display register bundle
package display_scan_ctrl_pkg;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_ERR   = 7'b0110110;
    localparam logic [3:0] DIG_OFF   = 4'b1111;
    localparam logic [0:0] ST_BLANK  = 1'b0;
    localparam logic [0:0] ST_SHOW   = 1'b1;
    typedef struct packed {
        logic [15:0] val;
        logic [3:0]  dp;
        logic [3:0]  en;
        logic [3:0]  dash;
    } disp_t;
endpackage

// File: rtl/display_scan_ctrl_hex7seg.sv
// hex7seg: nibble to active-low seven-segment glyph, seg[6]=g .. seg[0]=a
module hex7seg
    import display_scan_ctrl_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);
    always_comb
        case (nib)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = SEG_ERR;
        endcase
endmodule

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: 4-digit seven-segment scan with blanking gap and frame-synchronous double buffering
module display_scan_ctrl
    import display_scan_ctrl_pkg::*;
#(
    parameter int PRESCALE = 50000,
    parameter int BLANK    = 4
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] val,
    input  logic [3:0]  dp,
    input  logic [3:0]  en,
    input  logic [3:0]  dash,
    output logic [6:0]  L,
    output logic [3:0]  Dig,
    output logic        H,
    output logic        frame_done,
    output logic        upd_ack
);
    localparam int CW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    logic [CW-1:0] cnt;
    logic [1:0]    d;
    logic          pending, last, fb, on;
    logic [0:0]    st;
    logic [3:0]    nib;
    logic [6:0]    glyph;
    disp_t         sh, ac, in_d;
    assign in_d = {val, dp, en, dash};
    assign last = cnt == CW'(PRESCALE - 1);
    assign fb = last && d == 2'd3;
    assign st = cnt < CW'(BLANK) ? ST_BLANK : ST_SHOW;
    assign on = st == ST_SHOW && ac.en[d];
    assign nib = ac.val[{d, 2'b00} +: 4];
    assign frame_done = fb;
    assign upd_ack = fb && !rst && (pending || load);
    hex7seg u_hex (.nib(nib), .seg(glyph));
    // a load on the boundary cycle bypasses the shadow so it is never a frame late
    always_ff @(posedge clk)
        if (rst) begin
            cnt     <= '0;
            d       <= '0;
            pending <= 1'b0;
            sh      <= '0;
            ac      <= '0;
            Dig     <= DIG_OFF;
            L       <= SEG_BLANK;
            H       <= 1'b1;
        end else begin
            cnt     <= last ? '0 : cnt + 1'b1;
            d       <= last ? d + 1'b1 : d;
            sh      <= load ? in_d : sh;
            pending <= !fb && (pending || load);
            ac      <= fb && load ? in_d : fb && pending ? sh : ac;
            Dig     <= on ? ~(4'b0001 << d) : DIG_OFF;
            L       <= on ? (ac.dash[d] ? SEG_DASH : glyph) : SEG_BLANK;
            H       <= !(on && ac.dp[d]);
        end
endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: directed scenarios plus random loads/resets against a cycle-count based display model
module tb_display_scan_ctrl;
    localparam int P = 8, B = 2, F = 4 * P;
    localparam logic [6:0] GL [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                       7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic clk = 0, rst = 1, load = 0;
    logic [15:0] val = 0;
    logic [3:0] dp = 0, en = 0, dash = 0;
    logic [6:0] L;
    logic [3:0] Dig;
    logic H, frame_done, upd_ack;
    int checks = 0, fails = 0, t = 0, n_ack = 0, n_fd = 0, n0 = 0;
    bit started = 0, pend = 0;
    logic [15:0] sv = 0, av = 0;
    logic [3:0] sdp = 0, sen = 0, sds = 0, adp = 0, aen = 0, ads = 0;
    logic [3:0] e_dig = 4'hF;
    logic [6:0] e_l = 7'h7F;
    logic e_h = 1;
    int c, k;
    bit fb, show;
    logic [6:0] gsel;

    display_scan_ctrl #(.PRESCALE(P), .BLANK(B)) dut (
        .clk(clk), .rst(rst), .load(load), .val(val), .dp(dp), .en(en), .dash(dash),
        .L(L), .Dig(Dig), .H(H), .frame_done(frame_done), .upd_ack(upd_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s actual=%h expected=%h t=%0d", nm, a, e, t);
        end
    endtask

    // model: position in the frame follows purely from cycles since reset
    always_comb begin
        c = t % P;
        k = (t / P) % 4;
        fb = (t % F) == F - 1;
        show = c >= B && aen[k];
        gsel = ads[k] ? 7'h3F : GL[av[4*k +: 4]];
    end

    always @(posedge clk)
        if (rst) begin
            t <= 0;
            pend <= 0;
            {sv, sdp, sen, sds} <= '0;
            {av, adp, aen, ads} <= '0;
            e_dig <= 4'hF;
            e_l <= 7'h7F;
            e_h <= 1;
            started <= 1;
        end else begin
            t <= t + 1;
            e_dig <= show ? ~(4'b0001 << k) : 4'hF;
            e_l <= show ? gsel : 7'h7F;
            e_h <= !(show && adp[k]);
            if (load) {sv, sdp, sen, sds} <= {val, dp, en, dash};
            if (fb && load) {av, adp, aen, ads} <= {val, dp, en, dash};
            else if (fb && pend) {av, adp, aen, ads} <= {sv, sdp, sen, sds};
            pend <= !fb && (pend || load);
        end

    always @(negedge clk)
        if (started) begin
            chk("dig", Dig, e_dig);
            chk("seg", L, e_l);
            chk("dp", H, e_h);
            chk("frame_done", frame_done, fb);
            chk("upd_ack", upd_ack, fb && !rst && (pend || load));
            if (upd_ack) n_ack++;
            if (frame_done) n_fd++;
        end

    task automatic cyc();
        @(posedge clk);
        #1 load = 0;
    endtask

    task automatic goto(input int tt);
        for (int i = 0; i < 2 * F && (t % F) != tt; i++) cyc();
    endtask

    task automatic wait_ack();
        int m;
        m = n_ack;
        for (int i = 0; i < 2 * F && n_ack == m; i++) cyc();
        chk("ack_seen", n_ack - m, 1);
    endtask

    task automatic ld(input logic [15:0] v, input logic [3:0] p, input logic [3:0] e, input logic [3:0] s);
        val = v; dp = p; en = e; dash = s; load = 1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_dig", Dig, 4'hF);
        chk("rst_seg", L, 7'h7F);
        chk("rst_h", H, 1);
        @(posedge clk);
        #1 rst = 0;
        n_fd = 0; n_ack = 0;
        repeat (64) cyc();
        chk("idle_fd_count", n_fd, 2);
        chk("idle_ack_count", n_ack, 0);
        n0 = n_ack;
        ld(16'h3210, 4'b0100, 4'b1111, 4'b0000);
        cyc();
        wait_ack();
        goto(4); @(negedge clk);
        chk("d0_dig", Dig, 4'b1110); chk("d0_seg", L, 7'h40); chk("d0_h", H, 1);
        goto(20); @(negedge clk);
        chk("d2_dig", Dig, 4'b1011); chk("d2_seg", L, 7'h24); chk("d2_h", H, 0);
        goto(28); @(negedge clk);
        chk("d3_dig", Dig, 4'b0111); chk("d3_seg", L, 7'h30); chk("d3_h", H, 1);
        goto(2);
        n0 = n_ack;
        ld(16'hAAAA, 4'b0000, 4'b1111, 4'b0000);
        cyc(); cyc();
        ld(16'h5555, 4'b0000, 4'b1111, 4'b0000);
        cyc();
        goto(4); @(negedge clk);
        chk("double_load_acks", n_ack - n0, 1);
        chk("double_load_seg", L, 7'h12);
        goto(31);
        ld(16'hFFFF, 4'b0000, 4'b1111, 4'b0000);
        @(negedge clk);
        chk("bypass_ack", upd_ack, 1);
        chk("bypass_fd", frame_done, 1);
        cyc();
        goto(4); @(negedge clk);
        chk("bypass_seg", L, 7'h0E); chk("bypass_dig", Dig, 4'b1110);
        cyc();
        ld(16'h0000, 4'b0000, 4'b1010, 4'b0010);
        cyc();
        wait_ack();
        goto(4); @(negedge clk); chk("dis0_dig", Dig, 4'hF);
        goto(10); @(negedge clk); chk("d1_blank_dig", Dig, 4'hF);
        goto(11); @(negedge clk); chk("d1_show_dig", Dig, 4'b1101);
        goto(12); @(negedge clk); chk("dash_seg", L, 7'h3F);
        goto(20); @(negedge clk); chk("dis2_dig", Dig, 4'hF);
        goto(5);
        ld(16'h1234, 4'b1111, 4'b1111, 4'b0000);
        cyc();
        goto(21);
        rst = 1;
        cyc();
        rst = 0;
        @(negedge clk);
        chk("mid_rst_dig", Dig, 4'hF); chk("mid_rst_seg", L, 7'h7F);
        chk("mid_rst_h", H, 1); chk("mid_rst_fd", frame_done, 0);
        n0 = n_ack;
        repeat (2 * F) cyc();
        chk("rst_drops_pending", n_ack - n0, 0);
        for (int i = 0; i < 3000; i++) begin
            cyc();
            rst = ($urandom % 400) == 0;
            val = 16'($urandom); dp = 4'($urandom); en = 4'($urandom); dash = 4'($urandom);
            load = ($urandom % 6) == 0;
        end
        cyc();
        rst = 0;
        repeat (4) cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
